cdb_arbiter: RTL and testbench

Common-data-bus arbiter for the out-of-order pipeline's complete stage. It collects finished results from the functional units, buffers them per unit, and picks one per cycle by round-robin. The winner is broadcast as a registered CDB word that drives the physical register file write port (tag, value, RegDest) and the ROB completion port. It is the write-side counterpart of the PRF.

---
 rtl/cdb_pkg.sv | 25 ++
 rtl/cdb_fifo.sv | 61 ++++++
 rtl/cdb_arbiter.sv | 135 +++++++++++++
 tb/tb_cdb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared types and helpers for the common-data-bus arbiter.
//   TAG_W_DEF / DATA_W_DEF / ROB_W_DEF : default field widths. cdb_entry_t
//     is built from these, so cdb_arbiter must be instantiated with matching
//     TAG_W / DATA_W / ROB_W.
//   cdb_entry_t : one buffered functional-unit result.
//   next_rr()   : round-robin pointer advance after a grant.
package cdb_pkg;

  localparam int TAG_W_DEF  = 6;
  localparam int DATA_W_DEF = 32;
  localparam int ROB_W_DEF  = 5;

  typedef struct packed {
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
    logic                  regdest;
    logic [ROB_W_DEF-1:0]  rob;
  } cdb_entry_t;

  // Unit after the winner, wrapping at n_fu.
  function automatic int next_rr(input int grant, input int n_fu);
    return (grant + 1 >= n_fu) ? 0 : grant + 1;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: DEPTH-entry FIFO of cdb_entry_t for one functional unit.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : discard all entries (same effect as rst)
//   push, din  : write din at the tail (ignored when full)
//   pop, head  : head is the oldest entry; pop removes it (ignored when empty)
//   count      : current occupancy, 0..DEPTH
//   full/empty : occupancy flags
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  cdb_entry_t    din,
  input  logic          pop,
  output cdb_entry_t    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  cdb_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers functional-unit results and broadcasts one per cycle
// on a registered common data bus, chosen round-robin.
//   clk, rst     : clock, synchronous active-high reset (priority over flush)
//   flush        : drop all buffered results, rr_ptr back to 0
//   fu_valid/fu_ready, fu_tag, fu_data, fu_regdest, fu_rob : per-unit result ports
//   cdb_valid, cdb_tag, cdb_data, cdb_regdest, cdb_rob, cdb_grant : registered broadcast
//
// Handshake: unit i transfers a result on any rising edge where
// fu_valid[i] & fu_ready[i]. fu_ready depends only on the registered buffer
// count (plus flush/rst), never on fu_valid or on a same-cycle pop, so a full
// buffer stays not-ready even while its head is being broadcast.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_FU   = 4,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROB_W  = ROB_W_DEF,
  parameter int DEPTH  = 2,
  localparam int GW = (N_FU > 1) ? $clog2(N_FU) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [N_FU-1:0]          fu_valid,
  output logic [N_FU-1:0]          fu_ready,
  input  logic [N_FU*TAG_W-1:0]    fu_tag,
  input  logic [N_FU*DATA_W-1:0]   fu_data,
  input  logic [N_FU-1:0]          fu_regdest,
  input  logic [N_FU*ROB_W-1:0]    fu_rob,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic                     cdb_regdest,
  output logic [ROB_W-1:0]         cdb_rob,
  output logic [GW-1:0]            cdb_grant
);

  localparam int CW = $clog2(DEPTH + 1);

  cdb_entry_t      fu_entry [N_FU];
  cdb_entry_t      head     [N_FU];
  logic [CW-1:0]   cnt      [N_FU];
  logic [N_FU-1:0] push;
  logic [N_FU-1:0] pop;
  logic [N_FU-1:0] full;
  logic [N_FU-1:0] empty;

  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   grant;
  logic            found;
  cdb_entry_t      winner;

  for (genvar i = 0; i < N_FU; i++) begin : g_fu
    assign fu_entry[i].tag     = fu_tag[i*TAG_W +: TAG_W];
    assign fu_entry[i].data    = fu_data[i*DATA_W +: DATA_W];
    assign fu_entry[i].regdest = fu_regdest[i];
    assign fu_entry[i].rob     = fu_rob[i*ROB_W +: ROB_W];

    assign fu_ready[i] = (cnt[i] < CW'(DEPTH)) & ~flush & ~rst;
    assign push[i]     = fu_valid[i] & fu_ready[i];

    cdb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[i]),
      .din   (fu_entry[i]),
      .pop   (pop[i]),
      .head  (head[i]),
      .count (cnt[i]),
      .full  (full[i]),
      .empty (empty[i])
    );

    // A ready unit can never be pushing into a full buffer.
    always_ff @(posedge clk) begin
      if (!rst && push[i]) assert (!full[i]);
    end
  end

  // Walk upward from rr_ptr (mod N_FU); first non-empty head wins.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < N_FU; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_FU) idx = idx - N_FU;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        grant = GW'(idx);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (found) pop[grant] = 1'b1;
  end

  assign winner = head[grant];

  // Output word and rr_ptr. Tag 0 is the hardwired zero register: the word
  // still completes in the ROB but must not write the PRF.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      cdb_valid   <= 1'b0;
      cdb_regdest <= 1'b0;
      cdb_tag     <= '0;
      cdb_data    <= '0;
      cdb_rob     <= '0;
      cdb_grant   <= '0;
    end else if (flush) begin
      rr_ptr      <= '0;
      cdb_valid   <= 1'b0;
      cdb_regdest <= 1'b0;
    end else begin
      cdb_valid <= found;
      if (found) begin
        cdb_tag     <= winner.tag;
        cdb_data    <= winner.data;
        cdb_rob     <= winner.rob;
        cdb_grant   <= grant;
        cdb_regdest <= winner.regdest & (winner.tag != '0);
        rr_ptr      <= GW'(next_rr(int'(grant), N_FU));
      end else begin
        cdb_regdest <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: vector table, hand-written corner sequences and random
// traffic for cdb_arbiter, checked against a queue-based reference model.
module tb_cdb_arbiter;

  localparam int N_FU   = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int ROB_W  = 5;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              regdest;
    logic [ROB_W-1:0]  rob;
  } ent_t;

  typedef struct {
    logic [3:0]   v;
    logic [23:0]  tag;
    logic [127:0] data;
    logic [3:0]   rd;
    logic [19:0]  rob;
    logic         rst;
    logic         e_valid;
    logic [5:0]   e_tag;
    logic [31:0]  e_data;
    logic         e_rd;
    logic [4:0]   e_rob;
    logic [1:0]   e_grant;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst = 1'b1;
  logic                   flush = 1'b0;
  logic [N_FU-1:0]        fu_valid = '0;
  logic [N_FU-1:0]        fu_ready;
  logic [N_FU*TAG_W-1:0]  fu_tag = '0;
  logic [N_FU*DATA_W-1:0] fu_data = '0;
  logic [N_FU-1:0]        fu_regdest = '0;
  logic [N_FU*ROB_W-1:0]  fu_rob = '0;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [DATA_W-1:0]      cdb_data;
  logic                   cdb_regdest;
  logic [ROB_W-1:0]       cdb_rob;
  logic [1:0]             cdb_grant;

  cdb_arbiter #(
    .N_FU(N_FU), .TAG_W(TAG_W), .DATA_W(DATA_W), .ROB_W(ROB_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_tag(fu_tag),
    .fu_data(fu_data), .fu_regdest(fu_regdest), .fu_rob(fu_rob),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_regdest(cdb_regdest), .cdb_rob(cdb_rob), .cdb_grant(cdb_grant)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  ent_t        mq [N_FU][$];
  int          m_rr = 0;
  logic        m_valid = 1'b0;
  logic        m_regdest = 1'b0;
  logic [5:0]  m_tag = '0;
  logic [31:0] m_data = '0;
  logic [4:0]  m_rob = '0;
  logic [1:0]  m_grant = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic ent_t offered(input int i);
    ent_t e;
    e.tag     = fu_tag[i*TAG_W +: TAG_W];
    e.data    = fu_data[i*DATA_W +: DATA_W];
    e.regdest = fu_regdest[i];
    e.rob     = fu_rob[i*ROB_W +: ROB_W];
    return e;
  endfunction

  // One clock edge of the behavioural model: oldest result of the first
  // non-empty unit at or after the pointer is broadcast; accepted offers
  // join the back of their unit's queue.
  task automatic model_edge();
    logic [N_FU-1:0] rdy;
    int   w;
    ent_t e;
    for (int i = 0; i < N_FU; i++) rdy[i] = (mq[i].size() < DEPTH);
    if (rst || flush) begin
      for (int i = 0; i < N_FU; i++) mq[i].delete();
      m_rr      = 0;
      m_valid   = 1'b0;
      m_regdest = 1'b0;
      if (rst) begin
        m_tag = '0; m_data = '0; m_rob = '0; m_grant = '0;
      end
      return;
    end
    w = -1;
    for (int k = 0; k < N_FU; k++) begin
      int j;
      j = (m_rr + k) % N_FU;
      if (w < 0 && mq[j].size() > 0) w = j;
    end
    if (w >= 0) begin
      e         = mq[w].pop_front();
      m_valid   = 1'b1;
      m_tag     = e.tag;
      m_data    = e.data;
      m_rob     = e.rob;
      m_regdest = e.regdest && (e.tag != 0);
      m_grant   = 2'(w);
      m_rr      = (w + 1) % N_FU;
    end else begin
      m_valid   = 1'b0;
      m_regdest = 1'b0;
    end
    for (int i = 0; i < N_FU; i++)
      if (fu_valid[i] && rdy[i]) mq[i].push_back(offered(i));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_offer(input int i, input int tag, input logic [31:0] data,
                           input logic rd, input int rob);
    fu_valid[i]                  = 1'b1;
    fu_tag[i*TAG_W +: TAG_W]     = TAG_W'(tag);
    fu_data[i*DATA_W +: DATA_W]  = data;
    fu_regdest[i]                = rd;
    fu_rob[i*ROB_W +: ROB_W]     = ROB_W'(rob);
  endtask

  // Inputs are already driven; check ready, clock once, check the word.
  task automatic step(input string nm);
    #1;
    for (int i = 0; i < N_FU; i++)
      chk($sformatf("%s ready%0d", nm, i), 64'(fu_ready[i]),
          64'((mq[i].size() < DEPTH) && !flush && !rst));
    model_edge();
    @(posedge clk);
    #1;
    chk({nm, " valid"},   64'(cdb_valid),   64'(m_valid));
    chk({nm, " regdest"}, 64'(cdb_regdest), 64'(m_regdest));
    chk({nm, " tag"},     64'(cdb_tag),     64'(m_tag));
    chk({nm, " data"},    64'(cdb_data),    64'(m_data));
    chk({nm, " rob"},     64'(cdb_rob),     64'(m_rob));
    chk({nm, " grant"},   64'(cdb_grant),   64'(m_grant));
  endtask

  vec_t vecs [13];

  initial begin
    int last_grant;
    logic prev_valid;

    // Table: inputs for one cycle, expected word after that edge.
    vecs[0]  = '{4'b0100, {6'd0, 6'd5, 6'd0, 6'd0}, {32'd0, 32'hDEADBEEF, 64'd0}, 4'b0100,
                 {5'd0, 5'd3, 10'd0}, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 5'd0, 2'd0};
    vecs[1]  = '{4'b0000, 24'd0, 128'd0, 4'b0000, 20'd0, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b1, 5'd3, 2'd2};
    vecs[2]  = '{4'b0000, 24'd0, 128'd0, 4'b0000, 20'd0, 1'b0, 1'b0, 6'd5, 32'hDEADBEEF, 1'b0, 5'd3, 2'd2};
    vecs[3]  = '{4'b0010, 24'd0, {64'd0, 32'h12345678, 32'd0}, 4'b0010,
                 {10'd0, 5'd7, 5'd0}, 1'b0, 1'b0, 6'd5, 32'hDEADBEEF, 1'b0, 5'd3, 2'd2};
    vecs[4]  = '{4'b0000, 24'd0, 128'd0, 4'b0000, 20'd0, 1'b0, 1'b1, 6'd0, 32'h12345678, 1'b0, 5'd7, 2'd1};
    vecs[5]  = '{4'b0000, 24'd0, 128'd0, 4'b0000, 20'd0, 1'b0, 1'b0, 6'd0, 32'h12345678, 1'b0, 5'd7, 2'd1};
    vecs[6]  = '{4'b0000, 24'd0, 128'd0, 4'b0000, 20'd0, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 5'd0, 2'd0};
    vecs[7]  = '{4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'b1111,
                 {5'd4, 5'd3, 5'd2, 5'd1}, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 5'd0, 2'd0};
    vecs[8]  = '{4'b0000, 24'd0, 128'd0, 4'b0000, 20'd0, 1'b0, 1'b1, 6'd10, 32'hA0, 1'b1, 5'd1, 2'd0};
    vecs[9]  = '{4'b0000, 24'd0, 128'd0, 4'b0000, 20'd0, 1'b0, 1'b1, 6'd11, 32'hA1, 1'b1, 5'd2, 2'd1};
    vecs[10] = '{4'b0000, 24'd0, 128'd0, 4'b0000, 20'd0, 1'b0, 1'b1, 6'd12, 32'hA2, 1'b1, 5'd3, 2'd2};
    vecs[11] = '{4'b0000, 24'd0, 128'd0, 4'b0000, 20'd0, 1'b0, 1'b1, 6'd13, 32'hA3, 1'b1, 5'd4, 2'd3};
    vecs[12] = '{4'b0000, 24'd0, 128'd0, 4'b0000, 20'd0, 1'b0, 1'b0, 6'd13, 32'hA3, 1'b0, 5'd4, 2'd3};

    // ---- reset ----
    rst = 1'b1;
    step("reset");
    chk("reset cdb_valid",   64'(cdb_valid),   64'd0);
    chk("reset cdb_regdest", 64'(cdb_regdest), 64'd0);
    chk("reset cdb_tag",     64'(cdb_tag),     64'd0);
    chk("reset cdb_data",    64'(cdb_data),    64'd0);
    chk("reset cdb_grant",   64'(cdb_grant),   64'd0);
    rst = 1'b0;

    // ---- table ----
    for (int r = 0; r < 13; r++) begin
      fu_valid   = vecs[r].v;
      fu_tag     = vecs[r].tag;
      fu_data    = vecs[r].data;
      fu_regdest = vecs[r].rd;
      fu_rob     = vecs[r].rob;
      rst        = vecs[r].rst;
      flush      = 1'b0;
      step($sformatf("vec%0d", r));
      chk($sformatf("vec%0d exp valid", r),   64'(cdb_valid),   64'(vecs[r].e_valid));
      chk($sformatf("vec%0d exp tag", r),     64'(cdb_tag),     64'(vecs[r].e_tag));
      chk($sformatf("vec%0d exp data", r),    64'(cdb_data),    64'(vecs[r].e_data));
      chk($sformatf("vec%0d exp regdest", r), 64'(cdb_regdest), 64'(vecs[r].e_rd));
      chk($sformatf("vec%0d exp rob", r),     64'(cdb_rob),     64'(vecs[r].e_rob));
      chk($sformatf("vec%0d exp grant", r),   64'(cdb_grant),   64'(vecs[r].e_grant));
    end
    rst = 1'b0;
    chk("rr_ptr after simultaneous", 64'(dut.rr_ptr), 64'd0);

    // ---- flush with buffers at 2,1,2,0 ----
    fu_valid = '0;
    for (int i = 0; i < 3; i++) set_offer(i, 20 + i, 32'h100 + 32'(i), 1'b1, i);
    step("fl_a");
    for (int i = 0; i < 3; i++) set_offer(i, 24 + i, 32'h200 + 32'(i), 1'b1, 4 + i);
    step("fl_b");
    fu_valid = '0;
    set_offer(0, 28, 32'h300, 1'b1, 8);
    step("fl_c");
    chk("fl_c grant", 64'(cdb_grant), 64'd1);
    fu_valid = 4'hF;
    flush    = 1'b1;
    step("fl_d");
    chk("flush cdb_valid",   64'(cdb_valid),   64'd0);
    chk("flush cdb_regdest", 64'(cdb_regdest), 64'd0);
    flush    = 1'b0;
    fu_valid = '0;
    set_offer(3, 33, 32'h33333333, 1'b1, 9);
    #1;
    chk("post-flush ready", 64'(fu_ready), 64'hF);
    step("fl_e");
    fu_valid = '0;
    step("fl_f");
    chk("post-flush valid", 64'(cdb_valid), 64'd1);
    chk("post-flush grant", 64'(cdb_grant), 64'd3);
    chk("post-flush tag",   64'(cdb_tag),   64'd33);

    // ---- fairness / backpressure ----
    rst = 1'b1;
    fu_valid = '0;
    step("fair_rst");
    rst = 1'b0;
    prev_valid = 1'b0;
    last_grant = 0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N_FU; i++)
        set_offer(i, 1 + ((c * 4 + i) % 63), {16'(c), 16'(i)}, 1'b1, (c + i) % 32);
      step($sformatf("fair%0d", c));
      if (c >= 1) chk($sformatf("fair%0d busy", c), 64'(cdb_valid), 64'd1);
      if (prev_valid && cdb_valid)
        chk($sformatf("fair%0d rotate", c), 64'(cdb_grant), 64'((last_grant + 1) % N_FU));
      prev_valid = cdb_valid;
      last_grant = int'(cdb_grant);
    end

    // ---- reset mid-stream with full buffers ----
    rst = 1'b1;
    step("mid_rst");
    chk("mid_rst valid",   64'(cdb_valid),   64'd0);
    chk("mid_rst regdest", 64'(cdb_regdest), 64'd0);
    chk("mid_rst tag",     64'(cdb_tag),     64'd0);
    chk("mid_rst data",    64'(cdb_data),    64'd0);
    chk("mid_rst rob",     64'(cdb_rob),     64'd0);
    chk("mid_rst grant",   64'(cdb_grant),   64'd0);
    rst = 1'b0;
    fu_valid = '0;
    for (int c = 0; c < 3; c++) begin
      step($sformatf("post_rst%0d", c));
      chk($sformatf("post_rst%0d no stale", c), 64'(cdb_valid), 64'd0);
    end

    // ---- random traffic ----
    for (int c = 0; c < 400; c++) begin
      fu_valid = '0;
      for (int i = 0; i < N_FU; i++) begin
        if ($urandom_range(0, 2) != 0)
          set_offer(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)),
                    $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
      end
      flush = ($urandom_range(0, 29) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      step($sformatf("rnd%0d", c));
    end
    rst = 1'b0;
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
